// File: rtl/app_spi_responder.sv
// app_spi_responder: SPI mode-0 responder that turns {RW, ADDR} + DATA frames
//   into single-cycle register-bus reads and writes, oversampling async pins.
// Latency: pin edge -> event 3 OPB_CLK cycles; REG_WE 1 cycle after final rise event.
// Backpressure: none; the register bus must accept any strobe in the cycle it is issued.
//
// Ports:
//   OPB_CLK / OPB_RST        system clock, synchronous active-high reset
//   APP_FPGA_SPI_CLK/CS_N/MOSI/MISO  SPI pins (inputs asynchronous)
//   REG_ADDR/WDATA/WE/RE     register bus out; REG_RDATA sampled 1 cycle after REG_RE
//   BUSY                     synchronized CS active
//   FRAME_ERR                one-cycle pulse when a frame is cut short by CS release
module app_spi_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  OPB_CLK,
  input  logic                  OPB_RST,
  input  logic                  APP_FPGA_SPI_CLK,
  input  logic                  APP_FPGA_SPI0_CS_N,
  input  logic                  APP_FPGA_SPI0_MOSI,
  output logic                  APP_FPGA_SPI0_MISO,
  output logic [ADDR_WIDTH-1:0] REG_ADDR,
  output logic [DATA_WIDTH-1:0] REG_WDATA,
  output logic                  REG_WE,
  output logic                  REG_RE,
  input  logic [DATA_WIDTH-1:0] REG_RDATA,
  output logic                  BUSY,
  output logic                  FRAME_ERR
);
  localparam int FRAME_LEN = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(ADDR_WIDTH);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_RD, S_WR, S_DONE} state_t;

  // [0] and [1] are the synchronizer stages, [2] is the edge-detect register.
  logic [2:0] sclk_sync_q, sclk_sync_d;
  logic [2:0] cs_sync_q,   cs_sync_d;
  logic [2:0] mosi_sync_q, mosi_sync_d;

  // After reset, CS_N must be seen high before a frame may start, so that the
  // tail of a frame interrupted by reset is not mistaken for a new frame.
  logic [1:0] settle_q, settle_d;
  logic       armed_q,  armed_d;

  state_t                  state_q,   state_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [ADDR_WIDTH-1:0]   hdr_q,     hdr_d;
  logic [DATA_WIDTH-2:0]   rx_q,      rx_d;
  logic [DATA_WIDTH-1:0]   tx_q,      tx_d;
  logic                    miso_q,    miso_d;
  logic [ADDR_WIDTH-1:0]   addr_q,    addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q,   wdata_d;
  logic                    we_q,      we_d;
  logic                    re_q,      re_d;
  logic                    load_q,    load_d;
  logic                    err_q,     err_d;

  logic                    rise, fall, cs_fall, cs_rise, mosi_bit, last_rise;
  logic [ADDR_WIDTH:0]     hdr_shift;
  logic [DATA_WIDTH-1:0]   rx_shift;

  assign rise      = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign fall      = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2] & armed_q;
  assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
  assign mosi_bit  = mosi_sync_q[1];
  assign last_rise = rise && (bit_cnt_q == DATA_LAST);
  assign hdr_shift = {hdr_q, mosi_bit};
  assign rx_shift  = {rx_q, mosi_bit};

  always_comb begin
    sclk_sync_d = {sclk_sync_q[1:0], APP_FPGA_SPI_CLK};
    cs_sync_d   = {cs_sync_q[1:0],   APP_FPGA_SPI0_CS_N};
    mosi_sync_d = {mosi_sync_q[1:0], APP_FPGA_SPI0_MOSI};
    settle_d    = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
    armed_d     = armed_q | ((settle_q == 2'd3) & cs_sync_q[2]);

    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    hdr_d     = hdr_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    miso_d    = miso_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
    load_d    = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          state_d   = S_HDR;
          bit_cnt_d = '0;
          hdr_d     = '0;
          rx_d      = '0;
        end
      end
      S_HDR: begin
        if (cs_rise) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (rise) begin
          hdr_d     = hdr_shift[ADDR_WIDTH-1:0];
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == HDR_LAST) begin
            addr_d = hdr_shift[ADDR_WIDTH-1:0];
            miso_d = 1'b0;
            if (hdr_shift[ADDR_WIDTH]) begin
              state_d = S_RD;
              re_d    = 1'b1;  // registered: high in the first RD cycle
            end else begin
              state_d = S_WR;
            end
          end
        end
      end
      S_RD: begin
        load_d = re_q;
        if (load_q) begin
          tx_d = REG_RDATA;
        end else if (fall) begin
          miso_d = tx_q[DATA_WIDTH-1];
          tx_d   = tx_q << 1;
        end
        if (rise) begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
        // A CS release coinciding with the final rise completes the frame.
        if (last_rise) begin
          state_d = cs_rise ? S_IDLE : S_DONE;
          miso_d  = 1'b0;
        end else if (cs_rise) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          miso_d  = 1'b0;
        end
      end
      S_WR: begin
        if (rise) begin
          rx_d      = rx_shift[DATA_WIDTH-2:0];
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
        if (last_rise) begin
          wdata_d = rx_shift;
          we_d    = 1'b1;
          state_d = cs_rise ? S_IDLE : S_DONE;
        end else if (cs_rise) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      S_DONE: begin
        miso_d = 1'b0;
        if (cs_rise) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge OPB_CLK) begin
    if (OPB_RST) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      settle_q    <= '0;
      armed_q     <= 1'b0;
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      hdr_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      miso_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      load_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      settle_q    <= settle_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      hdr_q       <= hdr_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      re_q        <= re_d;
      load_q      <= load_d;
      err_q       <= err_d;
    end
  end

  assign APP_FPGA_SPI0_MISO = miso_q & (state_q == S_RD);
  assign REG_ADDR           = addr_q;
  assign REG_WDATA          = wdata_q;
  assign REG_WE             = we_q;
  assign REG_RE             = re_q;
  assign BUSY               = ~cs_sync_q[1];
  assign FRAME_ERR          = err_q;

endmodule

// File: tb/tb_app_spi_responder.sv
// tb_app_spi_responder: drives SPI frames as bit-banged pins at OPB_CLK/8 and
//   scoreboards the register-bus strobes and MISO stream against bench-built
//   expectations.
module tb_app_spi_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        spi_clk, cs_n, mosi, miso;
  logic [6:0]  reg_addr;
  logic [31:0] reg_wdata, reg_rdata;
  logic        reg_we, reg_re, busy, frame_err;

  typedef struct packed {
    logic [6:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t        exp_wr[$], obs_wr[$];
  logic [6:0] exp_rd[$], obs_rd[$];
  int         err_cnt = 0;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  app_spi_responder dut (
    .OPB_CLK            (clk),
    .OPB_RST            (rst),
    .APP_FPGA_SPI_CLK   (spi_clk),
    .APP_FPGA_SPI0_CS_N (cs_n),
    .APP_FPGA_SPI0_MOSI (mosi),
    .APP_FPGA_SPI0_MISO (miso),
    .REG_ADDR           (reg_addr),
    .REG_WDATA          (reg_wdata),
    .REG_WE             (reg_we),
    .REG_RE             (reg_re),
    .REG_RDATA          (reg_rdata),
    .BUSY               (busy),
    .FRAME_ERR          (frame_err)
  );

  // Record every strobe cycle; a strobe wider than one cycle shows up as extra entries.
  always @(negedge clk) begin
    if (!rst) begin
      if (reg_we)    obs_wr.push_back({reg_addr, reg_wdata});
      if (reg_re)    obs_rd.push_back(reg_addr);
      if (frame_err) err_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Shift nbits of 'bits' (bits[nbits-1] first); MISO is sampled just before each rise.
  task automatic shift_bits(input int nbits, input logic [63:0] bits,
                            output logic [63:0] miso_bits, output logic busy_mid);
    miso_bits = '0;
    busy_mid  = 1'b0;
    for (int i = nbits - 1; i >= 0; i--) begin
      mosi = bits[i];
      tick(4);
      miso_bits = {miso_bits[62:0], miso};
      if (i == nbits - 1) busy_mid = busy;
      spi_clk = 1'b1;
      tick(4);
      spi_clk = 1'b0;
    end
  endtask

  task automatic send_frame(input int nbits, input logic [63:0] bits, input int gap,
                            output logic [63:0] miso_bits, output logic busy_mid);
    cs_n = 1'b0;
    shift_bits(nbits, bits, miso_bits, busy_mid);
    tick(4);
    cs_n = 1'b1;
    mosi = 1'b0;
    tick(gap);
  endtask

  task automatic test_reset;
    rst = 1'b1; spi_clk = 1'b0; cs_n = 1'b1; mosi = 1'b0; reg_rdata = '0;
    tick(3);
    checks++; if (miso !== 1'b0)      begin failures++; $display("FAIL rst_miso got=%b exp=0", miso); end
    checks++; if (reg_addr !== 7'h0)  begin failures++; $display("FAIL rst_addr got=%h exp=0", reg_addr); end
    checks++; if (reg_wdata !== '0)   begin failures++; $display("FAIL rst_wdata got=%h exp=0", reg_wdata); end
    checks++; if (reg_we !== 1'b0)    begin failures++; $display("FAIL rst_we got=%b exp=0", reg_we); end
    checks++; if (reg_re !== 1'b0)    begin failures++; $display("FAIL rst_re got=%b exp=0", reg_re); end
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL rst_ferr got=%b exp=0", frame_err); end
    rst = 1'b0;
    tick(8);
  endtask

  task automatic test_write;
    logic [63:0] m; logic b; int e0; wr_t e, o;
    e0 = err_cnt;
    exp_wr.push_back({7'h05, 32'hDEADBEEF});
    send_frame(40, 64'({1'b0, 7'h05, 32'hDEADBEEF}), 8, m, b);
    checks++; if (obs_wr.size() != exp_wr.size()) begin failures++; $display("FAIL wr_count got=%0d exp=%0d", obs_wr.size(), exp_wr.size()); end
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      e = exp_wr.pop_front(); o = obs_wr.pop_front();
      checks++; if (o.addr !== e.addr) begin failures++; $display("FAIL wr_addr got=%h exp=%h", o.addr, e.addr); end
      checks++; if (o.data !== e.data) begin failures++; $display("FAIL wr_data got=%h exp=%h", o.data, e.data); end
    end
    exp_wr.delete(); obs_wr.delete();
    checks++; if (err_cnt != e0)      begin failures++; $display("FAIL wr_ferr got=%0d exp=%0d", err_cnt, e0); end
    checks++; if (obs_rd.size() != 0) begin failures++; $display("FAIL wr_no_re got=%0d exp=0", obs_rd.size()); end
    checks++; if (m !== 64'h0)        begin failures++; $display("FAIL wr_miso got=%h exp=0", m); end
    obs_rd.delete();
  endtask

  task automatic test_read;
    logic [63:0] m; logic b; logic [6:0] e, o; int e0;
    e0 = err_cnt;
    reg_rdata = 32'h12345678;
    exp_rd.push_back(7'h05);
    send_frame(40, 64'({1'b1, 7'h05, 32'h0}), 8, m, b);
    checks++; if (obs_rd.size() != exp_rd.size()) begin failures++; $display("FAIL rd_count got=%0d exp=%0d", obs_rd.size(), exp_rd.size()); end
    while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
      e = exp_rd.pop_front(); o = obs_rd.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL rd_addr got=%h exp=%h", o, e); end
    end
    exp_rd.delete(); obs_rd.delete();
    checks++; if (m[31:0] !== 32'h12345678) begin failures++; $display("FAIL rd_miso_data got=%h exp=12345678", m[31:0]); end
    checks++; if (m[39:32] !== 8'h00)       begin failures++; $display("FAIL rd_miso_hdr got=%h exp=00", m[39:32]); end
    checks++; if (obs_wr.size() != 0)       begin failures++; $display("FAIL rd_no_we got=%0d exp=0", obs_wr.size()); end
    checks++; if (err_cnt != e0)            begin failures++; $display("FAIL rd_ferr got=%0d exp=%0d", err_cnt, e0); end
    obs_wr.delete();
  endtask

  task automatic test_abort;
    logic [63:0] m; logic b; int e0; wr_t e, o;
    e0 = err_cnt;
    send_frame(20, 64'({1'b0, 7'h10, 12'hABC}), 8, m, b);
    checks++; if (b !== 1'b1)            begin failures++; $display("FAIL abort_busy_mid got=%b exp=1", b); end
    checks++; if (err_cnt != e0 + 1)     begin failures++; $display("FAIL abort_ferr got=%0d exp=%0d", err_cnt, e0 + 1); end
    checks++; if (obs_wr.size() != 0)    begin failures++; $display("FAIL abort_no_we got=%0d exp=0", obs_wr.size()); end
    checks++; if (busy !== 1'b0)         begin failures++; $display("FAIL abort_busy_end got=%b exp=0", busy); end
    obs_wr.delete();
    exp_wr.push_back({7'h11, 32'hCAFEF00D});
    send_frame(40, 64'({1'b0, 7'h11, 32'hCAFEF00D}), 8, m, b);
    checks++; if (obs_wr.size() != exp_wr.size()) begin failures++; $display("FAIL abort_next_count got=%0d exp=%0d", obs_wr.size(), exp_wr.size()); end
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      e = exp_wr.pop_front(); o = obs_wr.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL abort_next_wr got=%h exp=%h", o, e); end
    end
    exp_wr.delete(); obs_wr.delete();
    checks++; if (err_cnt != e0 + 1) begin failures++; $display("FAIL abort_next_ferr got=%0d exp=%0d", err_cnt, e0 + 1); end
  endtask

  task automatic test_overlength;
    logic [63:0] m; logic b; int e0; wr_t e, o;
    e0 = err_cnt;
    exp_wr.push_back({7'h22, 32'h13579BDF});
    send_frame(48, 64'({1'b0, 7'h22, 32'h13579BDF, 8'hFF}), 8, m, b);
    checks++; if (obs_wr.size() != exp_wr.size()) begin failures++; $display("FAIL ovl_count got=%0d exp=%0d", obs_wr.size(), exp_wr.size()); end
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      e = exp_wr.pop_front(); o = obs_wr.pop_front();
      checks++; if (o.addr !== e.addr) begin failures++; $display("FAIL ovl_addr got=%h exp=%h", o.addr, e.addr); end
      checks++; if (o.data !== e.data) begin failures++; $display("FAIL ovl_data got=%h exp=%h", o.data, e.data); end
    end
    exp_wr.delete(); obs_wr.delete();
    checks++; if (m !== 64'h0)    begin failures++; $display("FAIL ovl_miso got=%h exp=0", m); end
    checks++; if (err_cnt != e0)  begin failures++; $display("FAIL ovl_ferr got=%0d exp=%0d", err_cnt, e0); end
  endtask

  task automatic test_reset_midframe;
    logic [63:0] m; logic b; int e0; logic [6:0] e, o;
    reg_rdata = 32'h0BADF00D;
    exp_rd.push_back(7'h33);  // the read strobe issued before reset stands
    cs_n = 1'b0;
    shift_bits(12, 64'({1'b1, 7'h33, 4'h0}), m, b);
    rst = 1'b1;
    tick(1);
    checks++; if (reg_addr !== 7'h0)  begin failures++; $display("FAIL mrst_addr got=%h exp=0", reg_addr); end
    checks++; if (reg_wdata !== '0)   begin failures++; $display("FAIL mrst_wdata got=%h exp=0", reg_wdata); end
    checks++; if (reg_re !== 1'b0)    begin failures++; $display("FAIL mrst_re got=%b exp=0", reg_re); end
    checks++; if (reg_we !== 1'b0)    begin failures++; $display("FAIL mrst_we got=%b exp=0", reg_we); end
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL mrst_busy got=%b exp=0", busy); end
    checks++; if (miso !== 1'b0)      begin failures++; $display("FAIL mrst_miso got=%b exp=0", miso); end
    rst = 1'b0;
    e0 = err_cnt;
    shift_bits(28, 64'hFFFFFFF, m, b);
    tick(4);
    cs_n = 1'b1;
    tick(8);
    checks++; if (obs_rd.size() != exp_rd.size()) begin failures++; $display("FAIL mrst_rd_count got=%0d exp=%0d", obs_rd.size(), exp_rd.size()); end
    checks++; if (obs_wr.size() != 0)  begin failures++; $display("FAIL mrst_no_we got=%0d exp=0", obs_wr.size()); end
    checks++; if (err_cnt != e0)       begin failures++; $display("FAIL mrst_ferr got=%0d exp=%0d", err_cnt, e0); end
    checks++; if (m !== 64'h0)         begin failures++; $display("FAIL mrst_miso_tail got=%h exp=0", m); end
    exp_rd.delete(); obs_rd.delete(); obs_wr.delete();
    reg_rdata = 32'hA5C30F96;
    exp_rd.push_back(7'h44);
    send_frame(40, 64'({1'b1, 7'h44, 32'h0}), 8, m, b);
    checks++; if (obs_rd.size() != exp_rd.size()) begin failures++; $display("FAIL mrst_next_count got=%0d exp=%0d", obs_rd.size(), exp_rd.size()); end
    while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
      e = exp_rd.pop_front(); o = obs_rd.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL mrst_next_addr got=%h exp=%h", o, e); end
    end
    exp_rd.delete(); obs_rd.delete();
    checks++; if (m[31:0] !== 32'hA5C30F96) begin failures++; $display("FAIL mrst_next_miso got=%h exp=a5c30f96", m[31:0]); end
  endtask

  task automatic test_back_to_back;
    logic [63:0] m; logic b; int e0; wr_t e, o;
    e0 = err_cnt;
    exp_wr.push_back({7'h01, 32'hA5A5A5A5});
    send_frame(40, 64'({1'b0, 7'h01, 32'hA5A5A5A5}), 4, m, b);
    exp_wr.push_back({7'h02, 32'h5A5A5A5A});
    send_frame(40, 64'({1'b0, 7'h02, 32'h5A5A5A5A}), 8, m, b);
    checks++; if (obs_wr.size() != exp_wr.size()) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", obs_wr.size(), exp_wr.size()); end
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      e = exp_wr.pop_front(); o = obs_wr.pop_front();
      checks++; if (o.addr !== e.addr) begin failures++; $display("FAIL b2b_addr got=%h exp=%h", o.addr, e.addr); end
      checks++; if (o.data !== e.data) begin failures++; $display("FAIL b2b_data got=%h exp=%h", o.data, e.data); end
    end
    exp_wr.delete(); obs_wr.delete();
    checks++; if (err_cnt != e0) begin failures++; $display("FAIL b2b_ferr got=%0d exp=%0d", err_cnt, e0); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_overlength();
    test_reset_midframe();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/app_spi_responder.md
# app_spi_responder

SPI responder for the application-FPGA side of the host/APP serial link. It decodes framed SPI transactions (chip select, clock and MOSI in; MISO out) into single-cycle reads and writes on a local register bus. It is the far end of the SPI pins that the host side drives as software-controlled GPIO. All logic runs in the `OPB_CLK` domain. The SPI pins are asynchronous and are oversampled.

## Interface
Parameters:
- `DATA_WIDTH`, 32: data bits per frame and width of the register bus.
- `ADDR_WIDTH`, 7: address bits in the frame header.

Ports:
- `OPB_CLK`  in  1  system clock; the only clock.
- `OPB_RST`  in  1  reset, synchronous, active-high.
- `APP_FPGA_SPI_CLK`  in  1  SPI clock, asynchronous, mode 0 (CPOL=0, CPHA=0).
- `APP_FPGA_SPI0_CS_N`  in  1  frame select, active-low, asynchronous.
- `APP_FPGA_SPI0_MOSI`  in  1  serial data in, MSB first.
- `APP_FPGA_SPI0_MISO`  out  1  serial data out, MSB first.
- `REG_ADDR`  out  ADDR_WIDTH  register address; valid while `REG_RE` or `REG_WE` is high.
- `REG_WDATA`  out  DATA_WIDTH  write data; valid while `REG_WE` is high.
- `REG_WE`  out  1  one-cycle write strobe.
- `REG_RE`  out  1  one-cycle read strobe.
- `REG_RDATA`  in  DATA_WIDTH  read data; sampled exactly one cycle after `REG_RE`.
- `BUSY`  out  1  high while a frame is in progress (CS active).
- `FRAME_ERR`  out  1  one-cycle pulse when a frame aborts.

## Operation
- **Synchronizers:** SCLK, CS_N and MOSI each pass through a 2-FF synchronizer and a third edge-detect register.
  - A rising SCLK edge is an "rise" event and a falling edge is a "fall" event, each one cycle wide.
  - CS_N is likewise reduced to "cs_fall" (frame start) and "cs_rise" (frame end).
- **Frame format:** header byte `{RW, ADDR[ADDR_WIDTH-1:0]}` followed by DATA_WIDTH data bits. RW=1 is a read, RW=0 a write. Frame length is 1+ADDR_WIDTH+DATA_WIDTH bits (40 at defaults).
- **MOSI sampling:** MOSI is sampled (synchronized copy) on rise events. A bit counter increments on each rise event.
- **State machine** (IDLE, HDR, RD, WR, DONE):
  - IDLE: on cs_fall, clear the bit counter and go to HDR.
  - HDR: shift in header bits. On the rise event completing the header (bit index ADDR_WIDTH), latch `REG_ADDR` and go to RD if RW=1, else WR.
  - RD:
    - Assert `REG_RE` in the cycle after entering RD.
    - Load `REG_RDATA` into the TX shift register on the following cycle.
    - On each fall event, drive the TX MSB onto MISO, then shift left.
    - After the last data rise event, go to DONE.
  - WR:
    - Shift MOSI into the RX register.
    - On the rise event of the last data bit, go to DONE.
    - In the next cycle, drive `REG_WDATA` from the RX register and pulse `REG_WE` for one cycle.
  - DONE: ignore further SCLK edges and hold MISO at 0. Return to IDLE on cs_rise.
- **Abort:** cs_rise in HDR, RD or WR:
  - go to IDLE;
  - pulse `FRAME_ERR` in the same cycle as the transition;
  - issue no `REG_WE` (a `REG_RE` already issued stands).
- **cs_fall outside IDLE:** not possible without a preceding cs_rise; ignored if it occurs.
- **MISO:** 0 whenever the state is not RD. During RD, MISO is 0 until the first fall event after the header.
- **BUSY:** equals the synchronized, inverted CS_N.

## Timing
- **Reset values:** MISO=0, `REG_ADDR`=0, `REG_WDATA`=0, `REG_WE`=0, `REG_RE`=0, `BUSY`=0, `FRAME_ERR`=0, state IDLE, all shift registers and counters 0.
- **Reset mid-frame:** the block returns to IDLE with no strobe. It resumes only after a fresh cs_fall; bits of the interrupted frame that arrive after reset are ignored.
- **Pin-to-event latency:** 3 `OPB_CLK` cycles from a pin edge to the event cycle.
- **Write:** `REG_WE` is high exactly 1 cycle, 1 cycle after the event cycle of the final rise.
- **Read:** `REG_RE` is high 1 cycle after the header-completing rise event. `REG_RDATA` is captured on the next cycle.
- **SCLK requirement:**
  - SCLK high and low phases must each be ≥4 `OPB_CLK` cycles, so that the TX load precedes the first data fall event.
  - The CS_N setup before the first rise must be ≥4 cycles.
- **Simultaneous events:** a cs_rise in the same cycle as the final rise completes the frame (the strobe is issued) and takes priority over abort.

## Test plan
- **Write:** CS low, header 0x05, data 0xDEADBEEF, SCLK = OPB_CLK/8 -> one `REG_WE` pulse with `REG_ADDR`=0x05 and `REG_WDATA`=0xDEADBEEF; no `FRAME_ERR`.
- **Read:** header 0x85, `REG_RDATA`=0x12345678 held -> one `REG_RE` pulse with `REG_ADDR`=0x05; 32 MISO bits sampled on SCLK rise equal 0x12345678, MSB first.
- **Abort:** write header 0x10, CS released after 20 total bits -> `FRAME_ERR` pulses once; `REG_WE` never asserts; `BUSY` falls; a following valid write to 0x11 completes normally.
- **Over-length:** a 48-bit write frame -> exactly one `REG_WE` with data taken from bits 8..39; extra bits ignored; MISO stays 0.
- **Reset:** assert `OPB_RST` for 1 cycle after 12 bits of a read frame -> all outputs at reset values; no strobe until the next cs_fall; the next read frame succeeds.
- **Back-to-back:** two writes (0x01←0xA5A5A5A5, 0x02←0x5A5A5A5A) with 4 cycles of CS high between them -> two `REG_WE` pulses in order with the correct addresses and data.
